// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: register width, register count and the
// register-address type used by the register bank and its scoreboard.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;

  function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t a);
    logic [NREGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/reg_bank_if.sv
// Write, reserve and source-check bus into the register bank.
interface reg_bank_if;
  import cpu_pkg::*;

  logic              wr_en;
  reg_addr_t         wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  reg_addr_t         rsv_addr;
  logic              chk_a_en;
  logic              chk_b_en;
  reg_addr_t         chk_a;
  reg_addr_t         chk_b;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output chk_a_en, chk_b_en, chk_a, chk_b
  );
  modport slave (
    input wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input chk_a_en, chk_b_en, chk_a, chk_b
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register, set by reserve, cleared by write,
// and the decode-stage stall derived from it.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  reg_addr_t        wr_addr,
  input  logic             rsv_en,
  input  reg_addr_t        rsv_addr,
  input  logic             chk_a_en,
  input  logic             chk_b_en,
  input  reg_addr_t        chk_a,
  input  reg_addr_t        chk_b,
  output logic [NREGS-1:0] busy,
  output logic             stall
);
  logic [NREGS-1:0] busy_q, busy_d, clr_vec, set_vec;

  // Set wins over clear: a new producer supersedes the one whose result lands now.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_en)  clr_vec = reg_onehot(wr_addr);
    if (rsv_en) set_vec = reg_onehot(rsv_addr);
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Only the registered busy vector feeds stall; no same-cycle write bypass.
  assign stall = (chk_a_en & busy_q[chk_a]) | (chk_b_en & busy_q[chk_b]);
  assign busy  = busy_q;
endmodule

// File: rtl/reg_bank.sv
// Sixteen-entry general-purpose register bank with one write port; every
// register is exposed directly to the downstream read muxes.
module reg_bank
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  reg_bank_if.slave         bus,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15,
  output logic [NREGS-1:0]  busy,
  output logic              stall
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             wr_sel;

  always_comb begin
    wr_sel = '0;
    if (bus.wr_en) wr_sel = reg_onehot(bus.wr_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wr_sel[i]) regs[i] <= bus.wr_data;
    end
  end

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .chk_a_en (bus.chk_a_en),
    .chk_b_en (bus.chk_b_en),
    .chk_a    (bus.chk_a),
    .chk_b    (bus.chk_b),
    .busy     (busy),
    .stall    (stall)
  );

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];
endmodule
